// File: rtl/to8bit_sched.sv
// ---------------------------------------------------------------------------
// to8bit_sched
//
// Sequencer for the n-to-8-bit width-conversion path. It accepts one
// 8/16/32-bit word per valid/ready handshake, latches the word and its width
// mode, then emits it as a byte stream with one byte per output handshake.
// A phase counter selects the current byte, so no divided clocks are needed.
// The last-byte handshake and the next word accept can share a cycle, which
// gives full throughput with no bubble between words.
//
// Parameter LSB_FIRST : 1 = byte [7:0] first, 0 = most significant valid
//                       byte first.
// Optional build macro TO8BIT_SCHED_CNT_EN : adds the wordCnt output. This is
//                       a saturating count of words whose last byte was
//                       accepted.
// ---------------------------------------------------------------------------
module to8bit_sched #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [1:0]  dataS,
    input  logic [7:0]  dataIn,
    input  logic [15:0] dataIn16,
    input  logic [31:0] dataIn32,
    input  logic        inValid,
    output logic        inReady,
    output logic [7:0]  dataOut,
    output logic        outValid,
    input  logic        outReady,
    output logic        outLast,
    output logic [1:0]  phase,
    output logic        busy
`ifdef TO8BIT_SCHED_CNT_EN
    ,
    output logic [15:0] wordCnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Map the width select code to a byte count. 00 and 11 both mean 8-bit.
    function automatic logic [2:0] width_to_nbytes(input logic [1:0] sel);
        logic [2:0] n;
        case (sel)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            2'b10:   n = 3'd4;
            2'b11:   n = 3'd1;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    // Pick the producer word that matches the width select, zero-extended.
    function automatic logic [31:0] select_word(input logic [1:0]  sel,
                                                input logic [7:0]  d8,
                                                input logic [15:0] d16,
                                                input logic [31:0] d32);
        logic [31:0] w;
        case (sel)
            2'b01:   w = {16'h0000, d16};
            2'b10:   w = d32;
            2'b00:   w = {24'h000000, d8};
            2'b11:   w = {24'h000000, d8};
            default: w = {24'h000000, d8};
        endcase
        return w;
    endfunction

    // Translate the stream position into a byte lane of the held word.
    function automatic logic [1:0] byte_index(input logic [1:0] ph,
                                              input logic [2:0] nb);
        logic [2:0] rev;
        logic [1:0] idx;
        rev = nb - 3'd1 - {1'b0, ph};
        if (LSB_FIRST) begin
            idx = ph;
        end else begin
            idx = rev[1:0];
        end
        return idx;
    endfunction

    // Extract one byte lane from a 32-bit word.
    function automatic logic [7:0] pick_byte(input logic [31:0] w,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Architectural state
    state_t      state_r;
    logic [31:0] hold_r;
    logic [2:0]  nbytes_r;
    logic [1:0]  phase_r;

    // Next-state values
    state_t      state_s;
    logic [31:0] hold_s;
    logic [2:0]  nbytes_s;
    logic [1:0]  phase_s;

    // Decoded status and handshake terms
    logic        is_shift_s;
    logic        is_last_s;
    logic        in_ready_s;
    logic        out_valid_s;
    logic        out_last_s;
    logic        busy_s;
    logic [1:0]  phase_out_s;
    logic [7:0]  out_byte_s;
    logic        in_acc_s;
    logic        byte_acc_s;

    // Status decode, handshake generation and byte selection; reset forces all outputs low
    always_comb begin
        is_shift_s  = (state_r == ST_SHIFT);
        is_last_s   = ({1'b0, phase_r} == (nbytes_r - 3'd1));
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        busy_s      = 1'b0;
        phase_out_s = 2'd0;
        out_byte_s  = 8'h00;
        if (rst) begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
            busy_s      = 1'b0;
            phase_out_s = 2'd0;
        end else begin
            in_ready_s  = enb & (~is_shift_s | (is_last_s & outReady));
            out_valid_s = enb & is_shift_s;
            out_last_s  = is_shift_s & is_last_s;
            busy_s      = is_shift_s;
            phase_out_s = phase_r;
        end
        if (out_valid_s) begin
            out_byte_s = pick_byte(hold_r, byte_index(phase_r, nbytes_r));
        end else begin
            out_byte_s = 8'h00;
        end
        in_acc_s   = enb & inValid & in_ready_s;
        byte_acc_s = enb & out_valid_s & outReady;
    end

    // Next-state logic: load on input accept, advance or retire on byte accept
    always_comb begin
        state_s  = state_r;
        hold_s   = hold_r;
        nbytes_s = nbytes_r;
        phase_s  = phase_r;
        case (state_r)
            ST_IDLE: begin
                if (in_acc_s) begin
                    state_s  = ST_SHIFT;
                    hold_s   = select_word(dataS, dataIn, dataIn16, dataIn32);
                    nbytes_s = width_to_nbytes(dataS);
                    phase_s  = 2'd0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (in_acc_s) begin
                    // Only possible together with the last-byte handshake
                    state_s  = ST_SHIFT;
                    hold_s   = select_word(dataS, dataIn, dataIn16, dataIn32);
                    nbytes_s = width_to_nbytes(dataS);
                    phase_s  = 2'd0;
                end else if (byte_acc_s) begin
                    if (is_last_s) begin
                        state_s = ST_IDLE;
                        phase_s = 2'd0;
                    end else begin
                        phase_s = phase_r + 2'd1;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                phase_s  = 2'd0;
                nbytes_s = 3'd1;
            end
        endcase
    end

    // State register with synchronous reset; any word in flight is discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            hold_r   <= 32'h0000_0000;
            nbytes_r <= 3'd1;
            phase_r  <= 2'd0;
        end else begin
            state_r  <= state_s;
            hold_r   <= hold_s;
            nbytes_r <= nbytes_s;
            phase_r  <= phase_s;
        end
    end

    assign inReady  = in_ready_s;
    assign outValid = out_valid_s;
    assign outLast  = out_last_s;
    assign dataOut  = out_byte_s;
    assign phase    = phase_out_s;
    assign busy     = busy_s;

`ifdef TO8BIT_SCHED_CNT_EN
    logic [15:0] word_cnt_r;

    // Saturating count of words whose final byte was accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_r <= 16'h0000;
        end else if (byte_acc_s && is_last_s && (word_cnt_r != 16'hFFFF)) begin
            word_cnt_r <= word_cnt_r + 16'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign wordCnt = rst ? 16'h0000 : word_cnt_r;
`endif

endmodule

// File: tb/tb_to8bit_sched.sv
// ---------------------------------------------------------------------------
// Testbench for to8bit_sched. It runs two instances that share their inputs:
// one with LSB-first ordering and one with MSB-first ordering. A table of
// per-cycle vectors drives both, followed by hand-written burst and
// backpressure sequences. Define TO8BIT_SCHED_CNT_EN to check wordCnt.
// ---------------------------------------------------------------------------
module tb_to8bit_sched;

    logic        clk;
    logic        rst;
    logic        enb;
    logic [1:0]  dataS;
    logic [7:0]  dataIn;
    logic [15:0] dataIn16;
    logic [31:0] dataIn32;
    logic        inValid;
    logic        outReady;

    logic        inReady,  m_inReady;
    logic [7:0]  dataOut,  m_dataOut;
    logic        outValid, m_outValid;
    logic        outLast,  m_outLast;
    logic [1:0]  phase,    m_phase;
    logic        busy,     m_busy;
`ifdef TO8BIT_SCHED_CNT_EN
    logic [15:0] wordCnt, m_wordCnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cur    = 0;

    to8bit_sched #(.LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .enb(enb), .dataS(dataS), .dataIn(dataIn),
        .dataIn16(dataIn16), .dataIn32(dataIn32), .inValid(inValid),
        .inReady(inReady), .dataOut(dataOut), .outValid(outValid),
        .outReady(outReady), .outLast(outLast), .phase(phase), .busy(busy)
`ifdef TO8BIT_SCHED_CNT_EN
        , .wordCnt(wordCnt)
`endif
    );

    to8bit_sched #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .enb(enb), .dataS(dataS), .dataIn(dataIn),
        .dataIn16(dataIn16), .dataIn32(dataIn32), .inValid(inValid),
        .inReady(m_inReady), .dataOut(m_dataOut), .outValid(m_outValid),
        .outReady(outReady), .outLast(m_outLast), .phase(m_phase), .busy(m_busy)
`ifdef TO8BIT_SCHED_CNT_EN
        , .wordCnt(m_wordCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        r, e, iv;
        logic [1:0]  ds;
        logic [31:0] d;
        logic        ordy;
        logic        ir, ov;
        logic [7:0]  dout;
        logic        ol;
        logic [1:0]  ph;
        logic        b;
        logic [7:0]  msb;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic row(input logic r, input logic e, input logic iv,
                       input logic [1:0] ds, input logic [31:0] d,
                       input logic ordy, input logic ir, input logic ov,
                       input logic [7:0] dout, input logic ol,
                       input logic [1:0] ph, input logic b,
                       input logic [7:0] msb, input logic [15:0] cnt);
        vec_t v;
        v.r = r; v.e = e; v.iv = iv; v.ds = ds; v.d = d; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.dout = dout; v.ol = ol; v.ph = ph;
        v.b = b; v.msb = msb; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h expected %0h", nm, cur, act, exp);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [7:0] lsb_b [4];
    logic [7:0] msb_b [4];
    int         nb;
    logic       done;
    logic [7:0] v8;

    initial begin
        rst = 1'b1; enb = 1'b1; dataS = 2'b00; dataIn = 8'h00;
        dataIn16 = 16'h0000; dataIn32 = 32'h0; inValid = 1'b0; outReady = 1'b1;

        //   r     e     iv    ds     d              ordy  ir    ov    dout   ol    ph    b     msb    cnt
        row(1'b1, 1'b1, 1'b0, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd0);
        row(1'b1, 1'b1, 1'b0, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b00, 32'h00000000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd0);
        // 32-bit A1B2C3D4
        row(1'b0, 1'b1, 1'b1, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b0, 1'b1, 8'hD4, 1'b0, 2'd0, 1'b1, 8'hA1, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 2'd1, 1'b1, 8'hB2, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b0, 2'd2, 1'b1, 8'hC3, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd3, 1'b1, 8'hD4, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b00, 32'h00000000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd1);
        // back-to-back 16-bit 1234, 8-bit 55, 32-bit 01020304
        row(1'b0, 1'b1, 1'b1, 2'b01, 32'h00001234, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd1);
        row(1'b0, 1'b1, 1'b1, 2'b00, 32'h66778855, 1'b1, 1'b0, 1'b1, 8'h34, 1'b0, 2'd0, 1'b1, 8'h12, 16'd1);
        row(1'b0, 1'b1, 1'b1, 2'b00, 32'h66778855, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 2'd1, 1'b1, 8'h34, 16'd1);
        row(1'b0, 1'b1, 1'b1, 2'b10, 32'h01020304, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 2'd0, 1'b1, 8'h55, 16'd2);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'h01020304, 1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 2'd0, 1'b1, 8'h01, 16'd3);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'h01020304, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 2'd1, 1'b1, 8'h02, 16'd3);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'h01020304, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 2'd2, 1'b1, 8'h03, 16'd3);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'h01020304, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 2'd3, 1'b1, 8'h04, 16'd3);
        // backpressure on 16-bit BEEF
        row(1'b0, 1'b1, 1'b1, 2'b01, 32'h9999BEEF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd4);
        row(1'b0, 1'b1, 1'b0, 2'b01, 32'h9999BEEF, 1'b0, 1'b0, 1'b1, 8'hEF, 1'b0, 2'd0, 1'b1, 8'hBE, 16'd4);
        row(1'b0, 1'b1, 1'b0, 2'b01, 32'h9999BEEF, 1'b0, 1'b0, 1'b1, 8'hEF, 1'b0, 2'd0, 1'b1, 8'hBE, 16'd4);
        row(1'b0, 1'b1, 1'b0, 2'b01, 32'h9999BEEF, 1'b0, 1'b0, 1'b1, 8'hEF, 1'b0, 2'd0, 1'b1, 8'hBE, 16'd4);
        row(1'b0, 1'b1, 1'b0, 2'b01, 32'h9999BEEF, 1'b1, 1'b0, 1'b1, 8'hEF, 1'b0, 2'd0, 1'b1, 8'hBE, 16'd4);
        row(1'b0, 1'b1, 1'b0, 2'b01, 32'h9999BEEF, 1'b1, 1'b1, 1'b1, 8'hBE, 1'b1, 2'd1, 1'b1, 8'hEF, 16'd4);
        // 32-bit 11223344 with dataS change and enable pause after byte 1
        row(1'b0, 1'b1, 1'b1, 2'b10, 32'h11223344, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd5);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'h11223344, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 2'd0, 1'b1, 8'h11, 16'd5);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'h11223344, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 2'd1, 1'b1, 8'h22, 16'd5);
        row(1'b0, 1'b0, 1'b0, 2'b00, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 8'h00, 16'd5);
        row(1'b0, 1'b0, 1'b1, 2'b00, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 8'h00, 16'd5);
        row(1'b0, 1'b1, 1'b0, 2'b00, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 2'd2, 1'b1, 8'h33, 16'd5);
        row(1'b0, 1'b1, 1'b0, 2'b00, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 2'd3, 1'b1, 8'h44, 16'd5);
        // reset in the middle of CAFEF00D
        row(1'b0, 1'b1, 1'b1, 2'b10, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd6);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 2'd0, 1'b1, 8'hCA, 16'd6);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 2'd1, 1'b1, 8'hFE, 16'd6);
        row(1'b1, 1'b1, 1'b0, 2'b10, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b10, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd0);
        // 16-bit ABCD: LSB-first CD,AB / MSB-first AB,CD
        row(1'b0, 1'b1, 1'b1, 2'b01, 32'hFFFFABCD, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b01, 32'hFFFFABCD, 1'b1, 1'b0, 1'b1, 8'hCD, 1'b0, 2'd0, 1'b1, 8'hAB, 16'd0);
        row(1'b0, 1'b1, 1'b0, 2'b01, 32'hFFFFABCD, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b1, 2'd1, 1'b1, 8'hCD, 16'd0);
        // 8-bit words via codes 11 and 00, back to back
        row(1'b0, 1'b1, 1'b1, 2'b11, 32'h1234565A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd1);
        row(1'b0, 1'b1, 1'b1, 2'b00, 32'hDEADBEC3, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 2'd0, 1'b1, 8'h5A, 16'd1);
        row(1'b0, 1'b1, 1'b0, 2'b00, 32'hDEADBEC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 2'd0, 1'b1, 8'hC3, 16'd2);
        // enable low in IDLE blocks the input handshake
        row(1'b0, 1'b0, 1'b1, 2'b00, 32'h66778877, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd3);
        row(1'b0, 1'b1, 1'b0, 2'b00, 32'h66778877, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 16'd3);

        foreach (vq[k]) begin
            rst = vq[k].r; enb = vq[k].e; inValid = vq[k].iv; dataS = vq[k].ds;
            dataIn = vq[k].d[7:0]; dataIn16 = vq[k].d[15:0]; dataIn32 = vq[k].d;
            outReady = vq[k].ordy;
            #2;
            cur = k;
            chk("inReady",    32'(inReady),    32'(vq[k].ir));
            chk("outValid",   32'(outValid),   32'(vq[k].ov));
            chk("dataOut",    32'(dataOut),    32'(vq[k].dout));
            chk("outLast",    32'(outLast),    32'(vq[k].ol));
            chk("phase",      32'(phase),      32'(vq[k].ph));
            chk("busy",       32'(busy),       32'(vq[k].b));
            chk("msb_dataOut", 32'(m_dataOut), 32'(vq[k].msb));
            chk("msb_inReady", 32'(m_inReady), 32'(vq[k].ir));
            chk("msb_outValid", 32'(m_outValid), 32'(vq[k].ov));
            chk("msb_outLast", 32'(m_outLast), 32'(vq[k].ol));
            chk("msb_phase",  32'(m_phase),    32'(vq[k].ph));
            chk("msb_busy",   32'(m_busy),     32'(vq[k].b));
`ifdef TO8BIT_SCHED_CNT_EN
            chk("wordCnt",     32'(wordCnt),   32'(vq[k].cnt));
            chk("msb_wordCnt", 32'(m_wordCnt), 32'(vq[k].cnt));
`endif
            @(posedge clk);
            #1;
        end

        // Sustained 8-bit burst: one word accepted and one byte emitted per cycle
        cur = 1000;
        rst = 1'b0; enb = 1'b1; outReady = 1'b1; dataS = 2'b00; inValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v8 = 8'h10 + 8'(i);
            dataIn = v8;
            #2;
            chk("burst_inReady", 32'(inReady), 32'h1);
            if (i == 0) begin
                chk("burst_first_idle", 32'(outValid), 32'h0);
            end else begin
                chk("burst_data", 32'(dataOut), 32'(v8 - 8'h01));
                chk("burst_last", 32'(outLast), 32'h1);
            end
            @(posedge clk);
            #1;
            cur++;
        end
        inValid = 1'b0;
        #2;
        chk("burst_tail", 32'(dataOut), 32'h15);
        @(posedge clk);
        #1;
        #2;
        chk("burst_drained", 32'(outValid), 32'h0);

        // 32-bit word under irregular backpressure: bytes in order, none lost or repeated
        cur = 2000;
        dataS = 2'b10; dataIn32 = 32'h89ABCDEF; inValid = 1'b1; outReady = 1'b1;
        #1;
        chk("bp_accept_ready", 32'(inReady), 32'h1);
        @(posedge clk);
        #1;
        inValid = 1'b0; dataS = 2'b00; dataIn32 = 32'h0;
        nb = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            outReady = ((c % 3) != 0);
            #2;
            if (outValid && outReady) begin
                if (nb < 4) begin
                    lsb_b[nb] = dataOut;
                    msb_b[nb] = m_dataOut;
                end
                nb++;
                if (outLast) done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        chk("bp_done", 32'(done), 32'h1);
        chk("bp_count", 32'(nb), 32'd4);
        if (nb == 4) begin
            chk("bp_lsb0", 32'(lsb_b[0]), 32'hEF);
            chk("bp_lsb1", 32'(lsb_b[1]), 32'hCD);
            chk("bp_lsb2", 32'(lsb_b[2]), 32'hAB);
            chk("bp_lsb3", 32'(lsb_b[3]), 32'h89);
            chk("bp_msb0", 32'(msb_b[0]), 32'h89);
            chk("bp_msb1", 32'(msb_b[1]), 32'hAB);
            chk("bp_msb2", 32'(msb_b[2]), 32'hCD);
            chk("bp_msb3", 32'(msb_b[3]), 32'hEF);
        end else begin
            chk("bp_bytes_present", 32'(nb), 32'd4);
        end
        #2;
        chk("bp_idle_after", 32'(busy), 32'h0);
`ifdef TO8BIT_SCHED_CNT_EN
        chk("final_wordCnt", 32'(wordCnt), 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/to8bit_sched.md
Name: to8bit_sched

Overview:
- Sequencer for the n-to-8-bit width-conversion path. Accepts one 8/16/32-bit word per valid/ready handshake and latches the word and its width mode.
- Emits the word as a byte stream, one byte per output handshake, using an internal phase counter in place of divided clocks.
- Sits between the 8/16/32-bit word producers and the byte-wide consumer. Provides backpressure both ways and full throughput, with no bubble between words.

Parameters:
- LSB_FIRST, 1, 1: byte 0 ([7:0]) is emitted first; 0: the most significant valid byte is emitted first.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- enb  in  1  global enable; low freezes all state and blocks both handshakes.
- dataS  in  2  width select: 00/11 = 8-bit, 01 = 16-bit, 10 = 32-bit. Sampled only on input handshake.
- dataIn  in  8  8-bit word.
- dataIn16  in  16  16-bit word.
- dataIn32  in  32  32-bit word.
- inValid  in  1  input word valid.
- inReady  out  1  block can accept a word this cycle.
- dataOut  out  8  current byte.
- outValid  out  1  dataOut valid.
- outReady  in  1  consumer accepts byte.
- outLast  out  1  dataOut is the final byte of the current word.
- phase  out  2  index of current byte within word, 0..nBytes-1.
- busy  out  1  a word is held (state SHIFT).

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, hold=0, nBytes=1, phase=0. Outputs inReady=0, outValid=0, outLast=0, dataOut=0, busy=0. This holds in the cycle rst is high; inReady rises in the first cycle after rst falls, if enb=1.
- Reset mid-word discards the held word. No further bytes of it are emitted.
- States:
  - IDLE: no word held.
  - SHIFT: word held, bytes pending.
- Handshakes:
  - Input accept = enb & inValid & inReady.
  - Byte accept = enb & outValid & outReady.
- inReady = enb & (IDLE | (SHIFT & outLast & outReady)). The last-byte handshake and the next word accept may occur in the same cycle.
- On input accept:
  - hold <= selected input, zero-extended to 32 bits.
  - nBytes <= 1 (00/11), 2 (01) or 4 (10).
  - phase <= 0.
  - state <= SHIFT.
- Latency: a word accepted at edge N gives its first byte outValid=1 in the cycle after N.
- In SHIFT: outValid = enb; busy = 1; outLast = (phase == nBytes-1).
- Byte selection:
  - LSB_FIRST=1: dataOut = hold byte[phase].
  - LSB_FIRST=0: dataOut = hold byte[nBytes-1-phase].
  - dataOut = 0 whenever outValid = 0.
- On byte accept:
  - Not last: phase <= phase+1.
  - Last without input accept: state <= IDLE, phase <= 0.
  - Last with input accept: reload as above and stay in SHIFT.
- outReady low holds dataOut, phase and outLast stable. No byte is skipped or repeated.
- dataS and data inputs changing while in SHIFT have no effect on the current word.
- 8-bit mode: every byte has outLast=1, so sustained throughput is 1 word/cycle.
- 16-bit mode sustains 1 word per 2 cycles; 32-bit mode 1 word per 4 cycles.
- enb low: inReady=0, outValid=0, and all registers hold. When enb returns, the stream resumes at the same phase.
- phase never exceeds nBytes-1. It wraps to 0 only on reload or return to IDLE.

Optional Feature:
- Macro: TO8BIT_SCHED_CNT_EN.
- Defined:
  - Adds output wordCnt [15:0], counting words whose last byte was accepted.
  - Increments on byte accept with outLast=1, saturates at 16'hFFFF, and resets to 0 on rst.
  - Words discarded by reset are not counted.
- Not defined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, inValid=0.
  - During rst: all outputs 0.
  - After: inReady=1, outValid=0, busy=0.
- 32-bit word, LSB_FIRST=1: dataS=10, dataIn32=32'hA1B2C3D4, outReady=1.
  - Bytes D4, C3, B2, A1 on 4 consecutive cycles.
  - phase 0..3; outLast only on A1.
  - inReady=1 on the A1 cycle.
- Back-to-back mixed widths, outReady=1:
  - Words: 16-bit 16'h1234, then 8-bit 8'h55, then 32-bit 32'h01020304.
  - Byte stream 34, 12, 55, 04, 03, 02, 01 with no gap cycles.
  - outLast on 12, 55 and 01.
- Backpressure: 16-bit 16'hBEEF with outReady=0 for 3 cycles after the first byte is shown.
  - dataOut stays EF and phase stays 0 for those 3 cycles.
  - Then EF, BE once each after outReady=1.
- dataS changed mid-word and enb pause:
  - During a 32-bit word, drive dataS=00 and enb=0 for 2 cycles after byte 1.
  - outValid=0 during the pause.
  - On resume, remaining bytes 2, 3 are emitted in 32-bit mode.
- Reset mid-word and LSB_FIRST=0:
  - Assert rst after byte 1 of 32'hCAFEF00D: no further bytes, outValid=0, busy=0.
  - With LSB_FIRST=0: 16'hABCD yields AB, CD.
  - With TO8BIT_SCHED_CNT_EN: wordCnt counts only completed words.
